// File: rtl/mips32_pkg.sv
// Shared definitions for the MIPS32 memory side: responder FSM states and array geometry.
package mips32_pkg;

    localparam int MEM_DEPTH = 1024;
    localparam int DATA_W    = 32;
    localparam int CNT_W     = 4;   // wait counter width, covers WAIT_CYCLES 0..15

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mips32_sram.sv
// Single-port synchronous word array with registered read data; contents are never reset.
module mips32_sram
    import mips32_pkg::*;
#(
    parameter int DEPTH  = MEM_DEPTH,
    parameter int DATA_W = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk1,
    input  logic              en,
    input  logic              we,
    input  logic [AW-1:0]     addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // rdata only moves on a read, so it holds through the response phase
    always_ff @(posedge clk1) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/mips32_mem_responder.sv
// Memory slave for the MIPS32 core: one outstanding request, programmable wait states,
// out-of-range addresses flagged with resp_err instead of aliasing into the array.
module mips32_mem_responder
    import mips32_pkg::*;
#(
    parameter int DEPTH       = MEM_DEPTH,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic              busy
);

    localparam int AW = $clog2(DEPTH);

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    logic              lat_we;
    logic              lat_err;
    logic [AW-1:0]     lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              rd_valid;
    logic [DATA_W-1:0] sram_rdata;
    logic              accept;
    logic              access;
    logic              addr_err;

    // In RESP a new request rides on the response handshake, so ready follows resp_ready
    assign req_ready = rst_n && ((state == IDLE) || ((state == RESP) && resp_ready));
    assign accept    = req_valid && req_ready;
    assign addr_err  = req_addr >= ADDR_W'(DEPTH);
    assign access    = rst_n && (state == WAIT) && (cnt == '0);
    assign busy      = (state != IDLE);

    // Loads return array data; stores and errors return zero
    assign resp_rdata = rd_valid ? sram_rdata : '0;

    mips32_sram #(
        .DEPTH  (DEPTH),
        .DATA_W (DATA_W)
    ) u_sram (
        .clk1  (clk1),
        .en    (access && !lat_err),
        .we    (lat_we),
        .addr  (lat_addr),
        .wdata (lat_wdata),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk1) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            rd_valid   <= 1'b0;
            lat_we     <= 1'b0;
            lat_err    <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
        end else begin
            case (state)
                IDLE: ;
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                        resp_err   <= lat_err;
                        rd_valid   <= !lat_we && !lat_err;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_err   <= 1'b0;
                        rd_valid   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase

            // Accept overrides the IDLE fall-back of a RESP handshake
            if (accept) begin
                state     <= WAIT;
                cnt       <= CNT_W'(WAIT_CYCLES);
                lat_we    <= req_we;
                lat_err   <= addr_err;
                lat_addr  <= req_addr[AW-1:0];
                lat_wdata <= req_wdata;
            end
        end
    end

endmodule

// File: tb/tb_mips32_mem_responder.sv
// Directed bench: one responder with 2 wait states, a second with none.
module tb_mips32_mem_responder;

    logic        clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    // DUT A: WAIT_CYCLES = 2
    logic        a_rst_n, a_req_valid, a_req_ready, a_req_we;
    logic [31:0] a_req_addr, a_req_wdata, a_resp_rdata;
    logic        a_resp_valid, a_resp_ready, a_resp_err, a_busy;
    // DUT B: WAIT_CYCLES = 0
    logic        b_rst_n, b_req_valid, b_req_ready, b_req_we;
    logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
    logic        b_resp_valid, b_resp_ready, b_resp_err, b_busy;

    int tests = 0;
    int fails = 0;

    mips32_mem_responder #(.DEPTH(1024), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(2)) dut_a (
        .clk1(clk1), .rst_n(a_rst_n), .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_we(a_req_we), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
        .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_rdata(a_resp_rdata),
        .resp_err(a_resp_err), .busy(a_busy)
    );

    mips32_mem_responder #(.DEPTH(1024), .ADDR_W(32), .DATA_W(32), .WAIT_CYCLES(0)) dut_b (
        .clk1(clk1), .rst_n(b_rst_n), .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_we(b_req_we), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
        .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_rdata(b_resp_rdata),
        .resp_err(b_resp_err), .busy(b_busy)
    );

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Full transaction on A: accept, count edges to resp_valid, capture, handshake
    task automatic a_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
        a_req_valid = 1'b1; a_req_we = we; a_req_addr = addr; a_req_wdata = wdata;
        a_resp_ready = 1'b1;
        tick();
        a_req_valid = 1'b0;
        lat = 0;
        while (!a_resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rdata = a_resp_rdata;
        err   = a_resp_err;
        tick();
    endtask

    task automatic b_txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output int lat, output logic [31:0] rdata, output logic err);
        b_req_valid = 1'b1; b_req_we = we; b_req_addr = addr; b_req_wdata = wdata;
        b_resp_ready = 1'b1;
        tick();
        b_req_valid = 1'b0;
        lat = 0;
        while (!b_resp_valid && lat < 20) begin
            tick();
            lat++;
        end
        rdata = b_resp_rdata;
        err   = b_resp_err;
        tick();
    endtask

    initial begin
        int          lat;
        logic [31:0] rd, rd2;
        logic        er;

        a_rst_n = 1'b0; a_req_valid = 1'b0; a_req_we = 1'b0; a_req_addr = '0; a_req_wdata = '0;
        a_resp_ready = 1'b1;
        b_rst_n = 1'b0; b_req_valid = 1'b0; b_req_we = 1'b0; b_req_addr = '0; b_req_wdata = '0;
        b_resp_ready = 1'b1;

        // Reset then idle
        repeat (3) tick();
        chk("rst_req_ready",  {31'b0, a_req_ready},  32'd0);
        chk("rst_resp_valid", {31'b0, a_resp_valid}, 32'd0);
        chk("rst_busy",       {31'b0, a_busy},       32'd0);
        chk("rst_rdata",      a_resp_rdata,          32'd0);
        chk("rst_err",        {31'b0, a_resp_err},   32'd0);
        a_rst_n = 1'b1;
        b_rst_n = 1'b1;
        tick();
        chk("post_rst_ready", {31'b0, a_req_ready},  32'd1);

        // Store then load, 2 wait states
        a_txn(1'b1, 32'd5, 32'hDEADBEEF, lat, rd, er);
        chk("st5_latency", lat, 32'd3);
        chk("st5_rdata",   rd,  32'd0);
        chk("st5_err",     {31'b0, er}, 32'd0);
        chk("st5_idle",    {31'b0, a_busy}, 32'd0);
        a_txn(1'b0, 32'd5, 32'h0, lat, rd, er);
        chk("ld5_latency", lat, 32'd3);
        chk("ld5_rdata",   rd,  32'hDEADBEEF);
        a_txn(1'b1, 32'd6, 32'h600D0006, lat, rd, er);

        // Back-to-back: load 6 accepted on the handshake edge of load 5
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'd5;
        tick();
        a_req_valid = 1'b0;
        lat = 0;
        while (!a_resp_valid && lat < 20) begin tick(); lat++; end
        chk("b2b_first_rdata", a_resp_rdata, 32'hDEADBEEF);
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'd6;
        chk("b2b_ready_in_resp", {31'b0, a_req_ready}, 32'd1);
        tick();
        a_req_valid = 1'b0;
        chk("b2b_no_idle_busy", {31'b0, a_busy},       32'd1);
        chk("b2b_valid_drop",   {31'b0, a_resp_valid}, 32'd0);
        lat = 0;
        while (!a_resp_valid && lat < 20) begin tick(); lat++; end
        chk("b2b_second_latency", lat, 32'd3);
        chk("b2b_second_rdata",   a_resp_rdata, 32'h600D0006);
        tick();

        // Out of range
        a_txn(1'b0, 32'd1024, 32'h0, lat, rd, er);
        chk("oor_ld_err",   {31'b0, er}, 32'd1);
        chk("oor_ld_rdata", rd, 32'd0);
        a_txn(1'b1, 32'd1030, 32'h00000BAD, lat, rd, er);
        chk("oor_st_err",   {31'b0, er}, 32'd1);
        chk("oor_st_rdata", rd, 32'd0);
        a_txn(1'b0, 32'd6, 32'h0, lat, rd, er);
        chk("oor_no_alias", rd, 32'h600D0006);
        chk("in_range_err", {31'b0, er}, 32'd0);

        // Backpressure: response held, a waiting request is not taken
        a_resp_ready = 1'b0;
        a_req_valid = 1'b1; a_req_we = 1'b0; a_req_addr = 32'd5;
        tick();
        a_req_addr = 32'd6;
        lat = 0;
        while (!a_resp_valid && lat < 20) begin tick(); lat++; end
        chk("bp_latency", lat, 32'd3);
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("bp_valid_held", {31'b0, a_resp_valid}, 32'd1);
            chk("bp_rdata_held", a_resp_rdata, 32'hDEADBEEF);
            chk("bp_ready_low",  {31'b0, a_req_ready}, 32'd0);
        end
        chk("bp_err_held", {31'b0, a_resp_err}, 32'd0);
        a_req_valid = 1'b0;
        a_resp_ready = 1'b1;
        tick();
        chk("bp_release_valid", {31'b0, a_resp_valid}, 32'd0);
        chk("bp_release_idle",  {31'b0, a_busy},       32'd0);
        tick();
        chk("bp_single_hs",     {31'b0, a_resp_valid}, 32'd0);

        // Reset mid-store lands on the access edge
        a_txn(1'b1, 32'd7, 32'hA5A5A5A5, lat, rd, er);
        a_req_valid = 1'b1; a_req_we = 1'b1; a_req_addr = 32'd7; a_req_wdata = 32'h12345678;
        tick();
        a_req_valid = 1'b0;
        tick();
        tick();
        a_rst_n = 1'b0;
        tick();
        chk("midrst_valid", {31'b0, a_resp_valid}, 32'd0);
        chk("midrst_busy",  {31'b0, a_busy},       32'd0);
        chk("midrst_ready", {31'b0, a_req_ready},  32'd0);
        a_rst_n = 1'b1;
        tick();
        chk("midrst_no_resp", {31'b0, a_resp_valid}, 32'd0);
        a_txn(1'b0, 32'd7, 32'h0, lat, rd, er);
        chk("midrst_mem_kept", rd, 32'hA5A5A5A5);

        // Zero wait states
        b_txn(1'b1, 32'd9, 32'hCAFEF00D, lat, rd, er);
        chk("w0_st_latency", lat, 32'd1);
        chk("w0_st_rdata",   rd,  32'd0);
        b_txn(1'b0, 32'd9, 32'h0, lat, rd2, er);
        chk("w0_ld_latency", lat, 32'd1);
        chk("w0_ld_rdata",   rd2, 32'hCAFEF00D);
        chk("w0_ld_err",     {31'b0, er}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mips32_mem_responder.md
# mips32_mem_responder

Word-addressed 1024×32 memory slave that serves load/store and fetch requests from the pipelined MIPS32 core over a valid/ready request channel and returns one response per request on a valid/ready response channel. It sits on the memory side of the core's bus. It adds a configurable wait-state latency so the core's stall logic can be exercised against realistic memory timing. Out-of-range addresses are reported with an error flag rather than aliased.

## Interface
- DEPTH, 1024: number of 32-bit words; power of two.
- ADDR_W, 32: request address width; word address, not byte address.
- DATA_W, 32: data width.
- WAIT_CYCLES, 2: wait states inserted before the array access; legal range 0..15.

- clk1  in  1  single clock; all logic on posedge.
- rst_n  in  1  reset. One clock; reset is synchronous and active-low.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load/fetch.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  store data; ignored for loads.
- resp_valid  out  1  response present.
- resp_ready  in  1  core accepts the response.
- resp_rdata  out  DATA_W  load data; 0 for stores and errors.
- resp_err  out  1  address ≥ DEPTH.
- busy  out  1  state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid&&req_ready, latch we/addr/wdata, load wait counter with WAIT_CYCLES, go to WAIT.
- WAIT: counter decrements each cycle. In the cycle where counter==0, perform the access at that edge and go to RESP.
  - Read: resp_rdata ← mem[addr].
  - Write: mem[addr] ← wdata; resp_rdata ← 0.
  - err=1: no array access; resp_rdata ← 0.
- RESP: resp_valid=1. resp_rdata and resp_err hold stable until the handshake.
  - On resp_valid&&resp_ready: if req_valid, accept the new request in the same cycle (req_ready = resp_ready in RESP, combinational) and go to WAIT; else go to IDLE.
- Error detection: resp_err = (addr ≥ DEPTH), latched at accept. Only address bits [log2(DEPTH)-1:0] index the array.
- Only one request is outstanding at a time. Requests are served in order.
- Memory contents are not cleared by reset. They are undefined until written or preloaded by the bench via hierarchical $readmemh.

## Timing
- Reset (rst_n=0 at a posedge): state=IDLE, req_ready=0 while rst_n=0, resp_valid=0, resp_rdata=0, resp_err=0, busy=0, counter=0.
- req_ready rises combinationally once rst_n=1 and state=IDLE.
- Latency: resp_valid rises WAIT_CYCLES+1 edges after the accept edge. WAIT_CYCLES=0 gives a response on the next edge.
- Throughput:
  - With back-to-back handshakes in RESP: one request per WAIT_CYCLES+2 cycles.
  - Via IDLE: WAIT_CYCLES+3 cycles.
- Reset mid-operation:
  - In WAIT, reset wins over the access edge, so a pending store is dropped.
  - In RESP, the response is discarded.
- resp_ready held low: stays in RESP indefinitely, outputs frozen, req_ready=0.
- Store followed by load to the same address returns the new data. This is guaranteed by the single outstanding request.

## Structure
- mips32_pkg: state enum (IDLE/WAIT/RESP), MEM_DEPTH=1024 and DATA_W constants, shared with the core and bench.
- One sub-module: mips32_sram — single-port synchronous DEPTH×DATA_W array with we, addr, wdata and registered rdata. The responder's WAIT→RESP edge drives it.
- The responder owns the FSM, counter, request latch and error check.

## Test plan
- Reset then idle: rst_n=0 for 3 cycles → req_ready=0, resp_valid=0, busy=0. After release → req_ready=1 next cycle.
- Store/load, WAIT_CYCLES=2: store 0xDEADBEEF to addr 5 → resp_valid on 3rd edge after accept, rdata=0, err=0. Load addr 5 → rdata=0xDEADBEEF.
- Back-to-back requests: load 5 presented while RESP handshakes → accepted the same cycle, no IDLE cycle, next response 4 cycles later.
- Out of range: load addr 1024 → err=1, rdata=0. Store to 1030 → err=1 and mem[6] unchanged (aliasing check).
- Backpressure: hold resp_ready=0 for 10 cycles in RESP → rdata/err stable, req_ready=0. Release → single handshake.
- Reset mid-store: store 0x12345678 to addr 7, assert rst_n=0 during WAIT → no response, mem[7] retains its prior value. WAIT_CYCLES=0 variant: response on the next edge.
